// File: rtl/hazard3_jtag_dtm_sysclk.sv
// RISC-V JTAG-DTM (dtmcs v1) with the TAP oversampled on clk and a single-outstanding APB DMI master.
// TAP actions land 2-3 clk after each TCK edge; a busy DMI reports op=3 and sets sticky rather than stalling TCK.
module hazard3_jtag_dtm_sysclk #(
    parameter logic [31:0] IDCODE          = 32'h0000_0001,
    parameter logic [2:0]  DTMCS_IDLE_HINT = 3'd4,
    parameter int          W_ADDR          = 8,
    parameter int          W_IR            = 5,
    parameter int          SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tck,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic              dmihardreset_req,
    output logic              dmi_psel,
    output logic              dmi_penable,
    output logic              dmi_pwrite,
    output logic [W_ADDR-1:0] dmi_paddr,
    output logic [31:0]       dmi_pwdata,
    input  logic [31:0]       dmi_prdata,
    input  logic              dmi_pready,
    input  logic              dmi_pslverr
);

    localparam int W_DMI = W_ADDR + 34;
    localparam int W_DR  = W_DMI;

    localparam logic [W_IR-1:0] IR_IDCODE = W_IR'(32'h01);
    localparam logic [W_IR-1:0] IR_DTMCS  = W_IR'(32'h10);
    localparam logic [W_IR-1:0] IR_DMI    = W_IR'(32'h11);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        APB_IDLE, APB_SETUP, APB_ACCESS
    } apb_state_t;

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic                   tck_q;
    logic                   tck_s;
    logic                   tms_s;
    logic                   tdi_s;
    logic                   tck_rise;
    logic                   tck_fall;

    tap_state_t             tap_state;
    apb_state_t             apb_state;

    logic [W_IR-1:0]        ir;
    logic [W_IR-1:0]        ir_shift;
    logic [W_DR-1:0]        dr_shift;
    logic [W_DR-1:0]        dr_shift_next;
    logic [W_DR-1:0]        dr_capture;
    logic [7:0]             dr_top;

    logic [1:0]             sticky;
    logic [31:0]            last_rdata;
    logic                   discard;
    logic                   busy;
    logic [1:0]             dmi_status;
    logic [31:0]            dtmcs_rd;

    logic                   capture_dr;
    logic                   shift_dr_en;
    logic                   update_dr;
    logic                   capture_ir;
    logic                   shift_ir_en;
    logic                   update_ir;
    logic                   dmi_capture;
    logic                   dmi_update;
    logic                   dtmcs_update;
    logic                   dmi_req;
    logic                   dmi_start;
    logic [1:0]             upd_op;
    logic [31:0]            upd_data;
    logic [W_ADDR-1:0]      upd_addr;

    // TMS/TDI share TCK's pipeline depth so their samples line up with the detected edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_q    <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_q    <= tck_s;
        end
    end

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_q;
    assign tck_fall = ~tck_s & tck_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_state <= TLR;
        end else if (tck_rise) begin
            case (tap_state)
                TLR:      tap_state <= tms_s ? TLR      : RTI;
                RTI:      tap_state <= tms_s ? SEL_DR   : RTI;
                SEL_DR:   tap_state <= tms_s ? SEL_IR   : CAP_DR;
                CAP_DR:   tap_state <= tms_s ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: tap_state <= tms_s ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: tap_state <= tms_s ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: tap_state <= tms_s ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: tap_state <= tms_s ? UPD_DR   : SHIFT_DR;
                UPD_DR:   tap_state <= tms_s ? SEL_DR   : RTI;
                SEL_IR:   tap_state <= tms_s ? TLR      : CAP_IR;
                CAP_IR:   tap_state <= tms_s ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: tap_state <= tms_s ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: tap_state <= tms_s ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: tap_state <= tms_s ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: tap_state <= tms_s ? UPD_IR   : SHIFT_IR;
                UPD_IR:   tap_state <= tms_s ? SEL_DR   : RTI;
                default:  tap_state <= TLR;
            endcase
        end
    end

    assign capture_dr  = tck_rise && (tap_state == CAP_DR);
    assign shift_dr_en = tck_rise && (tap_state == SHIFT_DR);
    assign update_dr   = tck_rise && (tap_state == UPD_DR);
    assign capture_ir  = tck_rise && (tap_state == CAP_IR);
    assign shift_ir_en = tck_rise && (tap_state == SHIFT_IR);
    assign update_ir   = tck_rise && (tap_state == UPD_IR);

    always_ff @(posedge clk) begin
        if (rst) begin
            ir       <= IR_IDCODE;
            ir_shift <= '0;
        end else begin
            if (tap_state == TLR) begin
                ir <= IR_IDCODE;
            end else if (update_ir) begin
                ir <= ir_shift;
            end
            if (capture_ir) begin
                ir_shift <= W_IR'(2'b01);
            end else if (shift_ir_en) begin
                ir_shift <= {tdi_s, ir_shift[W_IR-1:1]};
            end
        end
    end

    assign busy       = (apb_state != APB_IDLE);
    assign dmi_status = (sticky != 2'd0) ? sticky : (busy ? 2'd3 : 2'd0);
    assign dtmcs_rd   = {14'd0, 2'b00, 1'b0, DTMCS_IDLE_HINT, sticky, 6'(W_ADDR), 4'd1};

    always_comb begin
        dr_capture = '0;
        dr_top     = 8'd0;
        case (ir)
            IR_IDCODE: begin
                dr_capture = W_DR'(IDCODE);
                dr_top     = 8'd31;
            end
            IR_DTMCS: begin
                dr_capture = W_DR'(dtmcs_rd);
                dr_top     = 8'd31;
            end
            IR_DMI: begin
                dr_capture = {dmi_paddr, last_rdata, dmi_status};
                dr_top     = 8'(W_DMI - 1);
            end
            default: begin
                dr_capture = '0;
                dr_top     = 8'd0;
            end
        endcase
    end

    // Bits above the selected length stay zero from capture, so a plain right shift is enough.
    always_comb begin
        dr_shift_next = dr_shift >> 1;
        for (int i = 0; i < W_DR; i++) begin
            if (i == int'(dr_top)) begin
                dr_shift_next[i] = tdi_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dr_shift <= '0;
        end else if (capture_dr) begin
            dr_shift <= dr_capture;
        end else if (shift_dr_en) begin
            dr_shift <= dr_shift_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tdo <= 1'b0;
        end else if (tck_fall) begin
            if (tap_state == SHIFT_IR) begin
                tdo <= ir_shift[0];
            end else if (tap_state == SHIFT_DR) begin
                tdo <= dr_shift[0];
            end else begin
                tdo <= 1'b0;
            end
        end
    end

    assign dmi_capture  = capture_dr && (ir == IR_DMI);
    assign dmi_update   = update_dr && (ir == IR_DMI);
    assign dtmcs_update = update_dr && (ir == IR_DTMCS);
    assign upd_op       = dr_shift[1:0];
    assign upd_data     = dr_shift[33:2];
    assign upd_addr     = dr_shift[W_DMI-1:34];
    assign dmi_req      = dmi_update && ((upd_op == 2'd1) || (upd_op == 2'd2));
    assign dmi_start    = dmi_req && (sticky == 2'd0) && !busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            apb_state        <= APB_IDLE;
            dmi_psel         <= 1'b0;
            dmi_penable      <= 1'b0;
            dmi_pwrite       <= 1'b0;
            dmi_paddr        <= '0;
            dmi_pwdata       <= '0;
            last_rdata       <= '0;
            sticky           <= 2'd0;
            discard          <= 1'b0;
            dmihardreset_req <= 1'b0;
        end else begin
            dmihardreset_req <= 1'b0;
            case (apb_state)
                APB_IDLE: begin
                    if (dmi_start) begin
                        apb_state  <= APB_SETUP;
                        dmi_psel   <= 1'b1;
                        dmi_pwrite <= (upd_op == 2'd2);
                        dmi_paddr  <= upd_addr;
                        dmi_pwdata <= upd_data;
                        discard    <= 1'b0;
                    end
                end
                APB_SETUP: begin
                    apb_state   <= APB_ACCESS;
                    dmi_penable <= 1'b1;
                end
                APB_ACCESS: begin
                    if (dmi_pready) begin
                        apb_state   <= APB_IDLE;
                        dmi_psel    <= 1'b0;
                        dmi_penable <= 1'b0;
                        discard     <= 1'b0;
                        if (!discard) begin
                            if (!dmi_pwrite) begin
                                last_rdata <= dmi_prdata;
                            end
                            if (dmi_pslverr && (sticky == 2'd0)) begin
                                sticky <= 2'd2;
                            end
                        end
                    end
                end
                default: begin
                    apb_state   <= APB_IDLE;
                    dmi_psel    <= 1'b0;
                    dmi_penable <= 1'b0;
                end
            endcase

            if ((dmi_capture || dmi_req) && busy) begin
                sticky <= 2'd3;
            end

            if (dtmcs_update && (dr_shift[16] || dr_shift[17])) begin
                sticky <= 2'd0;
            end
            // A hard reset orphans the in-flight access: it still completes on the bus, but its result is dropped.
            if (dtmcs_update && dr_shift[17]) begin
                dmihardreset_req <= 1'b1;
                if (busy) begin
                    discard <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard3_jtag_dtm_sysclk.sv
// Directed bench: JTAG bit-banged at 1/8 clk; DR captures and APB transfers checked against queued expectations.
module tb_hazard3_jtag_dtm_sysclk;

    localparam int W_ADDR = 8;
    localparam int W_IR   = 5;
    localparam logic [31:0] IDCODE = 32'h0000_0001;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tck = 1'b0;
    logic              tms = 1'b1;
    logic              tdi = 1'b0;
    logic              tdo;
    logic              dmihardreset_req;
    logic              dmi_psel;
    logic              dmi_penable;
    logic              dmi_pwrite;
    logic [W_ADDR-1:0] dmi_paddr;
    logic [31:0]       dmi_pwdata;
    logic [31:0]       dmi_prdata = 32'h0;
    logic              dmi_pready = 1'b0;
    logic              dmi_pslverr = 1'b0;

    hazard3_jtag_dtm_sysclk #(
        .IDCODE          (IDCODE),
        .DTMCS_IDLE_HINT (3'd4),
        .W_ADDR          (W_ADDR),
        .W_IR            (W_IR),
        .SYNC_STAGES     (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tck              (tck),
        .tms              (tms),
        .tdi              (tdi),
        .tdo              (tdo),
        .dmihardreset_req (dmihardreset_req),
        .dmi_psel         (dmi_psel),
        .dmi_penable      (dmi_penable),
        .dmi_pwrite       (dmi_pwrite),
        .dmi_paddr        (dmi_paddr),
        .dmi_pwdata       (dmi_pwdata),
        .dmi_prdata       (dmi_prdata),
        .dmi_pready       (dmi_pready),
        .dmi_pslverr      (dmi_pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
    } apb_t;

    apb_t        apb_q[$];
    logic [63:0] cap_q[$];
    int          total = 0;
    int          bad = 0;
    int          ready_delay = 0;
    bit          err_mode = 1'b0;
    int          acc_cnt = 0;
    int          hr_cycles = 0;
    logic        psel_d = 1'b0;
    logic        pen_d = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // APB completer: pready after ready_delay ACCESS cycles
    always @(negedge clk) begin
        if (dmi_psel && dmi_penable) begin
            dmi_pready  = (acc_cnt >= ready_delay);
            dmi_pslverr = err_mode && (acc_cnt >= ready_delay);
            acc_cnt++;
        end else begin
            dmi_pready  = 1'b0;
            dmi_pslverr = 1'b0;
            acc_cnt     = 0;
        end
    end

    always @(negedge clk) begin
        #1;
        if (dmihardreset_req) hr_cycles++;
        if (dmi_psel && !psel_d) chk("apb_setup_penable", dmi_penable, 0);
        if (dmi_psel && psel_d && !pen_d) chk("apb_access_penable", dmi_penable, 1);
        if (dmi_psel && dmi_penable && dmi_pready) begin
            total++;
            assert (apb_q.size() > 0) else begin
                bad++;
                $error("FAIL apb_unexpected observed=addr_%h expected=no_transfer", dmi_paddr);
            end
            if (apb_q.size() > 0) begin
                apb_t e;
                e = apb_q.pop_front();
                chk("apb_pwrite", dmi_pwrite, e.w);
                chk("apb_paddr", dmi_paddr, e.a);
                chk("apb_pwdata", dmi_pwdata, e.d);
            end
        end
        psel_d = dmi_psel;
        pen_d  = dmi_penable;
    end

    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v;
        tdi = tdi_v;
        tck = 1'b0;
        repeat (4) @(negedge clk);
        tdo_v = tdo;
        tck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic tms_step(input logic v);
        logic d;
        tck_cycle(v, 1'b0, d);
    endtask

    task automatic shift_ir(input logic [W_IR-1:0] code, output logic [W_IR-1:0] cap);
        logic d;
        tms_step(1); tms_step(1); tms_step(0); tms_step(0);
        for (int i = 0; i < W_IR; i++) begin
            tck_cycle(i == W_IR - 1, code[i], d);
            cap[i] = d;
        end
        tms_step(1); tms_step(0);
    endtask

    task automatic shift_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
        logic d;
        dout = '0;
        tms_step(1); tms_step(0); tms_step(0);
        for (int i = 0; i < len; i++) begin
            tck_cycle(i == len - 1, din[i], d);
            dout[i] = d;
        end
        tms_step(1); tms_step(0);
    endtask

    task automatic dr_check(input string tag, input int len, input logic [63:0] din, input logic [63:0] exp);
        logic [63:0] got;
        cap_q.push_back(exp);
        shift_dr(len, din, got);
        chk(tag, got, cap_q.pop_front());
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dmi_psel && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, dmi_psel, 0);
        chk({tag, "_queue"}, apb_q.size(), 0);
    endtask

    function automatic logic [63:0] dmi(input logic [7:0] a, input logic [31:0] d, input logic [1:0] o);
        return {22'd0, a, d, o};
    endfunction

    function automatic apb_t apb(input logic w, input logic [7:0] a, input logic [31:0] d);
        apb_t t;
        t.w = w;
        t.a = a;
        t.d = d;
        return t;
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W_IR-1:0] ircap;
        int n;

        repeat (4) @(negedge clk);
        chk("rst_tdo", tdo, 0);
        chk("rst_psel", dmi_psel, 0);
        chk("rst_penable", dmi_penable, 0);
        chk("rst_pwrite", dmi_pwrite, 0);
        chk("rst_paddr", dmi_paddr, 0);
        chk("rst_pwdata", dmi_pwdata, 0);
        chk("rst_hardreset", dmihardreset_req, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        tms_step(0);
        dr_check("idcode", 32, 64'd0, 64'(IDCODE));

        shift_ir(5'h10, ircap);
        chk("ir_capture", ircap, 5'b00001);
        dr_check("dtmcs_read", 32, 64'd0, 64'h4081);

        shift_ir(5'h11, ircap);
        apb_q.push_back(apb(1'b1, 8'h04, 32'hDEADBEEF));
        dr_check("dmi_cap_initial", 42, dmi(8'h04, 32'hDEADBEEF, 2'd2), dmi(8'h00, 32'h0, 2'd0));
        wait_idle("write_done");
        dr_check("dmi_after_write", 42, 64'd0, dmi(8'h04, 32'h0, 2'd0));

        dmi_prdata  = 32'h12345678;
        ready_delay = 50;
        apb_q.push_back(apb(1'b0, 8'h11, 32'h0));
        dr_check("dmi_read_launch", 42, dmi(8'h11, 32'h0, 2'd1), dmi(8'h04, 32'h0, 2'd0));
        dr_check("dmi_cap_busy", 42, dmi(8'h11, 32'h0, 2'd1), dmi(8'h11, 32'h0, 2'd3));
        wait_idle("busy_update_ignored");
        shift_ir(5'h10, ircap);
        dr_check("dtmcs_sticky_busy", 32, 64'h1_0000, 64'h4C81);
        dr_check("dtmcs_after_dmireset", 32, 64'd0, 64'h4081);
        shift_ir(5'h11, ircap);
        dr_check("dmi_read_data", 42, 64'd0, dmi(8'h11, 32'h12345678, 2'd0));

        ready_delay = 0;
        err_mode    = 1'b1;
        apb_q.push_back(apb(1'b1, 8'h20, 32'hCAFEF00D));
        dr_check("dmi_err_launch", 42, dmi(8'h20, 32'hCAFEF00D, 2'd2), dmi(8'h11, 32'h12345678, 2'd0));
        wait_idle("err_write_done");
        err_mode = 1'b0;
        dr_check("dmi_cap_err", 42, dmi(8'h21, 32'h1, 2'd2), dmi(8'h20, 32'h12345678, 2'd2));
        dr_check("dmi_err_ignored", 42, 64'd0, dmi(8'h20, 32'h12345678, 2'd2));
        chk("err_no_transfer_queue", apb_q.size(), 0);
        shift_ir(5'h10, ircap);
        dr_check("dtmcs_sticky_err", 32, 64'h1_0000, 64'h4881);

        dr_check("dtmcs_hardreset", 32, 64'h2_0000, 64'h4081);
        chk("hardreset_pulse_cycles", hr_cycles, 1);

        shift_ir(5'h1F, ircap);
        dr_check("bypass", 4, 64'b1011, 64'b0110);

        shift_ir(5'h10, ircap);
        repeat (5) tms_step(1);
        tms_step(0);
        dr_check("idcode_after_tms_reset", 32, 64'd0, 64'(IDCODE));

        shift_ir(5'h11, ircap);
        ready_delay = 1000;
        dr_check("dmi_launch_for_rst", 42, dmi(8'h30, 32'h55, 2'd2), dmi(8'h20, 32'h12345678, 2'd0));
        n = 0;
        while (!(dmi_psel && dmi_penable) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_access", dmi_psel && dmi_penable, 1);
        tms = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_psel", dmi_psel, 0);
        chk("rst_mid_penable", dmi_penable, 0);
        chk("rst_mid_paddr", dmi_paddr, 0);
        @(negedge clk);
        rst = 1'b0;
        ready_delay = 0;
        repeat (4) @(negedge clk);
        tms_step(0);
        dr_check("idcode_after_rst", 32, 64'd0, 64'(IDCODE));
        shift_ir(5'h11, ircap);
        dr_check("dmi_after_rst", 42, 64'd0, dmi(8'h00, 32'h0, 2'd0));
        chk("rst_no_transfer_queue", apb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
